if_prefetch_unit: RTL and testbench
===================================

// Module: if_prefetch_unit
// PURPOSE
// - Instruction-fetch front end. Owns the PC, issues in-order requests to the instruction memory and buffers the returned words in a DEPTH-entry queue.
// - Presents {inst, pc+4} to the IF/ID pipeline register through a valid/ready handshake.
// - Handles branch/jump redirects by flushing the queue and discarding in-flight responses.
// PARAMETERS
// - DEPTH     4             queue entries and max outstanding requests; power of two, >=2
// - RESET_PC  32'h00000000  first fetch address after reset
// PORTS
// - clk             in   1   clock, rising edge
// - rst             in   1   asynchronous, active-high reset
// - fetch_en        in   1   0: issue no new requests (responses are still accepted)
// - im_req          out  1   fetch request valid
// - im_addr         out  10  word address, fetch_pc[11:2]
// - im_gnt          in   1   request accepted this cycle (when im_req=1)
// - im_rvalid       in   1   response valid; responses return in request order, latency >=1
// - im_rdata        in   32  instruction word
// - out_valid       out  1   queue head valid
// - out_inst        out  32  head instruction; 32'h0 (NOP) when out_valid=0
// - out_pc4         out  32  head PC+4; 32'h0 when out_valid=0
// - out_ready       in   1   IF/ID accepts head (IFID_Write)
// - redirect_valid  in   1   branch taken / jump, 1-cycle pulse
// - redirect_pc     in   32  target; bits [1:0] ignored and forced to 00
// BEHAVIOUR
// - Reset (async): fetch_pc=resp_pc=RESET_PC; queue empty; outstanding=0; discard_cnt=0. While rst=1: im_req=0, out_valid=0, out_inst=0, out_pc4=0.
// - Issue: im_req = fetch_en & !redirect_valid & (occupancy + outstanding < DEPTH).
// - Issue handshake: im_req & im_gnt -> fetch_pc += 4, outstanding += 1. If im_gnt=0, im_req and im_addr hold stable.
// - Response (im_rvalid): outstanding -= 1.
//   - If discard_cnt > 0: discard_cnt -= 1; word dropped.
//   - Else: push {im_rdata, resp_pc+4}; resp_pc += 4.
// - Pop: out_valid & out_ready, i.e. a registered head with no bypass.
// - Minimum latency: request granted at cycle t, rvalid at t+1, out_valid at t+2.
// - Redirect cycle (highest priority):
//   - fetch_pc = resp_pc = {redirect_pc[31:2],2'b00}; queue cleared.
//   - discard_cnt = all requests still outstanding after this cycle. An im_rvalid in the same cycle is dropped and not counted.
//   - Any same-cycle pop and grant are ignored; im_req is forced to 0.
// - Simultaneous push and pop on a full queue is legal; occupancy is unchanged.
// - The issue limit guarantees no push ever overflows.
// - Counters: occupancy, outstanding and discard_cnt are $clog2(DEPTH+1) bits. fetch_pc wraps modulo 2^32.
// - Invariants, checked by assertions:
//   - occupancy + outstanding <= DEPTH
//   - discard_cnt <= outstanding
//   - no im_rvalid while outstanding=0
// - Reset mid-operation: all state is abandoned immediately. Fetch restarts at RESET_PC in the first cycle after rst falls.
// STRUCTURE
// - mips_pkg: RESET_PC default, NOP_INST=32'h0, IM_ADDR_W=10.
// - Sub-module fetch_fifo: synchronous FIFO with flush input, width 64 ({inst, pc4}), depth DEPTH, full/empty/count outputs.
// - Top level: PC/resp_pc registers, outstanding and discard counters, issue logic, output zeroing.
// TESTING
// Bench memory model: configurable latency L, im_gnt=1 unless stated, mem[a]=32'h1000_0000|a.
// - Reset, L=1, out_ready=1: cycle 0 im_addr=0; cycle 2 out_valid=1, out_inst=32'h10000000, out_pc4=4. Thereafter one instruction per cycle with pc4=8,12,...
// - Backpressure, DEPTH=4, out_ready=0: im_req drops after 4 grants and occupancy=4. Release out_ready: pc4 sequence 4,8,12,16,20 with nothing lost or duplicated.
// - Redirect with 2 in flight, L=3, redirect_pc=32'h43: next 2 rvalids dropped. First out_pc4=32'h44, out_inst=mem[16].
// - Redirect coinciding with rvalid, pop and grant, redirect_pc=32'h80: out_valid=0 next cycle. Next im_addr=10'h20; that grant is not counted.
// - im_gnt=0 for 3 cycles: im_addr constant, no outstanding growth, no output change.
// - rst pulsed mid-cycle with a full queue: out_valid/out_inst/out_pc4/im_req go 0 without a clock edge. Fetch resumes at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and bus payload types for the MIPS instruction-fetch front end.
package mips_pkg;

  localparam int unsigned IM_ADDR_W        = 10;
  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  // One buffered fetch result as seen by the IF/ID register.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a flush that discards all contents.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order memory requests and
// queues returned words for the IF/ID register, flushing on redirects.
module if_prefetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  output logic                 im_req,
  output logic [IM_ADDR_W-1:0] im_addr,
  input  logic                 im_gnt,
  input  logic                 im_rvalid,
  input  logic [31:0]          im_rdata,
  output logic                 out_valid,
  output logic [31:0]          out_inst,
  output logic [31:0]          out_pc4,
  input  logic                 out_ready,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard_cnt;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   in_use;
  logic [31:0]      redirect_tgt;
  logic             grant;
  logic             resp_keep;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic             unused_ok;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign in_use       = (CNT_W+1)'(occupancy) + (CNT_W+1)'(outstanding);

  // Queue slots plus in-flight requests never exceed DEPTH, so pushes cannot overflow.
  assign im_req    = ~rst & fetch_en & ~redirect_valid & (in_use < (CNT_W+1)'(DEPTH));
  assign im_addr   = fetch_pc[IM_ADDR_W+1:2];
  assign grant     = im_req & im_gnt;
  assign resp_keep = im_rvalid & (discard_cnt == '0) & ~redirect_valid;
  assign pop       = out_valid & out_ready & ~redirect_valid;

  assign push_entry = '{inst: im_rdata, pc4: resp_pc + 32'd4};

  assign out_valid = ~fifo_empty;
  assign out_inst  = out_valid ? head.inst : NOP_INST;
  assign out_pc4   = out_valid ? head.pc4  : 32'h0;
  assign unused_ok = ^{redirect_pc[1:0], fifo_full};

  // PC, response PC and request bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_tgt;
      resp_pc     <= redirect_tgt;
      outstanding <= outstanding - CNT_W'(im_rvalid);
      discard_cnt <= outstanding - CNT_W'(im_rvalid);
    end else begin
      if (grant)     fetch_pc <= fetch_pc + 32'd4;
      if (resp_keep) resp_pc  <= resp_pc + 32'd4;
      outstanding <= outstanding + CNT_W'(grant) - CNT_W'(im_rvalid);
      if (im_rvalid && discard_cnt != '0) discard_cnt <= discard_cnt - CNT_W'(1);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  a_budget: assert property (@(posedge clk) disable iff (rst) in_use <= (CNT_W+1)'(DEPTH));
  a_discard: assert property (@(posedge clk) disable iff (rst) discard_cnt <= outstanding);
  a_rvalid: assert property (@(posedge clk) disable iff (rst) !(im_rvalid && outstanding == '0));

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: latency-configurable memory, queue-level reference model,
// directed scenarios with literal expectations plus randomized traffic.
module tb_if_prefetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        im_req;
  logic [9:0]  im_addr;
  logic        im_gnt = 1'b0;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc4;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  always #5 clk = ~clk;

  if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .im_req(im_req), .im_addr(im_addr),
    .im_gnt(im_gnt), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc4(out_pc4), .out_ready(out_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct { logic [31:0] pc; logic stale; int due; } req_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc4; } ent_t;

  req_t        inflight[$];
  ent_t        q[$];
  logic [31:0] m_pc;
  int          cyc = 0;
  int          lat = 1;
  int          errors = 0;
  int          checks = 0;
  int          grants = 0;
  logic        d_en = 0, d_ready = 0, d_redir = 0, d_gnt = 1;
  logic [31:0] d_rpc = 0;
  logic [31:0] popped_pc4[$];
  logic [31:0] popped_inst[$];

  function automatic logic [31:0] mem_word(logic [31:0] pc);
    return 32'h1000_0000 | {22'd0, pc[11:2]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_model();
    inflight.delete();
    q.delete();
    m_pc   = 32'h0;
    grants = 0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check request, advance model.
  task automatic step();
    logic  rv;
    logic  exp_req;
    req_t  r;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_inst", out_inst, q.size() > 0 ? q[0].inst : 32'h0);
    chk("out_pc4", out_pc4, q.size() > 0 ? q[0].pc4 : 32'h0);
    rv = (inflight.size() > 0) && (inflight[0].due <= cyc);
    fetch_en       = d_en;
    out_ready      = d_ready;
    redirect_valid = d_redir;
    redirect_pc    = d_rpc;
    im_gnt         = d_gnt;
    im_rvalid      = rv;
    im_rdata       = rv ? mem_word(inflight[0].pc) : $urandom();
    #1;
    exp_req = d_en && !d_redir && (q.size() + inflight.size() < DEPTH);
    chk("im_req", 32'(im_req), 32'(exp_req));
    chk("im_addr", 32'(im_addr), {22'd0, m_pc[11:2]});
    if (im_req && im_gnt) grants++;
    if (out_valid && d_ready && !d_redir) begin
      popped_pc4.push_back(out_pc4);
      popped_inst.push_back(out_inst);
    end
    if (d_redir) begin
      if (rv) void'(inflight.pop_front());
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      q.delete();
      m_pc = {d_rpc[31:2], 2'b00};
    end else begin
      if (q.size() > 0 && d_ready) void'(q.pop_front());
      if (rv) begin
        r = inflight.pop_front();
        if (!r.stale) q.push_back('{mem_word(r.pc), r.pc + 32'd4});
      end
      if (exp_req && d_gnt) begin
        inflight.push_back('{pc: m_pc, stale: 1'b0, due: cyc + lat});
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    im_rvalid      = 1'b0;
    #1;
    chk("rst_im_req", 32'(im_req), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    d_redir = 0;
  endtask

  task automatic run_until_pop(int budget);
    popped_pc4.delete();
    popped_inst.delete();
    for (int i = 0; i < budget && popped_pc4.size() == 0; i++) step();
  endtask

  initial begin
    @(negedge clk);
    // Reset and streaming at latency 1.
    do_reset();
    chk("p1_addr0", 32'(im_addr), 32'h0);
    lat = 1; d_en = 1; d_ready = 1; d_gnt = 1;
    step(); step();
    chk("p1_valid_c2", 32'(out_valid), 32'h1);
    chk("p1_inst_c2", out_inst, 32'h1000_0000);
    chk("p1_pc4_c2", out_pc4, 32'h4);
    step();
    chk("p1_pc4_c3", out_pc4, 32'h8);
    step();
    chk("p1_pc4_c4", out_pc4, 32'hC);
    for (int i = 0; i < 10; i++) step();

    // Backpressure fills the queue, then drains in order.
    do_reset();
    d_ready = 0;
    for (int i = 0; i < 8; i++) step();
    chk("bp_grants", 32'(grants), 32'd4);
    chk("bp_req_low", 32'(im_req), 32'h0);
    popped_pc4.delete();
    d_ready = 1;
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 5; i++) begin
      logic [31:0] got;
      got = (popped_pc4.size() > i) ? popped_pc4[i] : 32'hDEAD_DEAD;
      chk("bp_seq", got, 32'(4 * (i + 1)));
    end

    // Redirect with two requests in flight at latency 3.
    do_reset();
    lat = 3; d_en = 1; d_ready = 1; d_gnt = 1;
    step(); step();
    d_redir = 1; d_rpc = 32'h43;
    step();
    d_redir = 0;
    run_until_pop(20);
    chk("rd1_pc4", popped_pc4.size() > 0 ? popped_pc4[0] : 32'hDEAD_DEAD, 32'h44);
    chk("rd1_inst", popped_inst.size() > 0 ? popped_inst[0] : 32'hDEAD_DEAD, 32'h1000_0010);

    // Redirect coinciding with response, pop and grant.
    do_reset();
    lat = 1; d_en = 1; d_ready = 1; d_gnt = 1;
    for (int i = 0; i < 5; i++) step();
    d_redir = 1; d_rpc = 32'h80;
    step();
    chk("rd2_valid", 32'(out_valid), 32'h0);
    chk("rd2_addr", 32'(im_addr), 32'h20);
    d_redir = 0;
    run_until_pop(20);
    chk("rd2_pc4", popped_pc4.size() > 0 ? popped_pc4[0] : 32'hDEAD_DEAD, 32'h84);
    chk("rd2_inst", popped_inst.size() > 0 ? popped_inst[0] : 32'hDEAD_DEAD, 32'h1000_0020);

    // Grant withheld for three cycles.
    do_reset();
    lat = 1; d_en = 1; d_ready = 0; d_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ng_addr", 32'(im_addr), 32'h0);
      chk("ng_valid", 32'(out_valid), 32'h0);
    end
    chk("ng_grants", 32'(grants), 32'h0);
    d_gnt = 1; d_ready = 1;
    for (int i = 0; i < 6; i++) step();

    // Asynchronous reset with a full queue.
    do_reset();
    lat = 1; d_en = 1; d_ready = 0; d_gnt = 1;
    for (int i = 0; i < 8; i++) step();
    chk("ar_full_valid", 32'(out_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_inst", out_inst, 32'h0);
    chk("ar_pc4", out_pc4, 32'h0);
    chk("ar_req", 32'(im_req), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    chk("ar_addr", 32'(im_addr), 32'h0);
    d_ready = 1;
    run_until_pop(10);
    chk("ar_first_pc4", popped_pc4.size() > 0 ? popped_pc4[0] : 32'hDEAD_DEAD, 32'h4);

    // Randomized traffic.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      lat = $urandom_range(1, 4);
      for (int i = 0; i < 400; i++) begin
        d_en    = ($urandom % 8) != 0;
        d_ready = ($urandom % 4) != 0;
        d_gnt   = ($urandom % 4) != 0;
        d_redir = ($urandom % 20) == 0;
        d_rpc   = $urandom;
        step();
      end
      d_redir = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
